// File: rtl/trip_pkg.sv
// Shared constants, the H:M:S record type and its packing helper for the trip odometer.
package trip_pkg;

    localparam int SPEED_W = 7;
    localparam int DIST_W  = 14;

    localparam int HMS_S_LSB = 0;
    localparam int HMS_S_W   = 6;
    localparam int HMS_M_LSB = 6;
    localparam int HMS_M_W   = 6;
    localparam int HMS_H_LSB = 12;
    localparam int HMS_H_W   = 7;
    localparam int HMS_W     = HMS_H_LSB + HMS_H_W;

    localparam logic [HMS_H_W-1:0] HMS_MAX_H   = 7'd99;
    localparam logic [HMS_S_W-1:0] MAX_MIN_SEC = 6'd59;
    localparam logic [DIST_W-1:0]  DIST_MAX    = 14'd9999;

    typedef struct packed {
        logic [HMS_H_W-1:0] hours;
        logic [HMS_M_W-1:0] minutes;
        logic [HMS_S_W-1:0] seconds;
    } hms_t;

    function automatic logic [HMS_W-1:0] pack_hms(input hms_t t);
        logic [HMS_W-1:0] p;
        p = '0;
        p[HMS_H_LSB +: HMS_H_W] = t.hours;
        p[HMS_M_LSB +: HMS_M_W] = t.minutes;
        p[HMS_S_LSB +: HMS_S_W] = t.seconds;
        return p;
    endfunction

endpackage

// File: rtl/trip_odometer_if.sv
// Sensor/control inputs and trip-data outputs of the trip odometer, grouped as one bundle.
interface trip_odometer_if;
    import trip_pkg::*;

    logic               reed;
    logic               trip_clear;
    logic [SPEED_W-1:0] speed;
    logic               speed_valid;

    logic               half_sec_pulse;
    logic               sec_pulse;
    logic               wheel_pulse;
    logic               moving;
    logic [DIST_W-1:0]  distance;
    logic [HMS_W-1:0]   HMS_time;
    logic [SPEED_W-1:0] max_speed;

    modport master (
        output reed, trip_clear, speed, speed_valid,
        input  half_sec_pulse, sec_pulse, wheel_pulse, moving, distance, HMS_time, max_speed
    );

    modport slave (
        input  reed, trip_clear, speed, speed_valid,
        output half_sec_pulse, sec_pulse, wheel_pulse, moving, distance, HMS_time, max_speed
    );

endinterface

// File: rtl/trip_timebase.sv
// Free-running cycle counter producing registered half-second and second pulses.
module trip_timebase #(
    parameter int CLK_FREQ = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic half_sec_pulse,
    output logic sec_pulse
);

    localparam int CNT_W = $clog2(CLK_FREQ);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_FREQ / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] tb_cnt;
    logic [CNT_W-1:0] tb_next;

    assign tb_next = (tb_cnt == FULL_LAST) ? '0 : tb_cnt + 1'b1;

    // Pulses decode the next count so they are high exactly while tb_cnt holds the decoded value.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            tb_cnt         <= '0;
            half_sec_pulse <= 1'b0;
            sec_pulse      <= 1'b0;
        end else begin
            tb_cnt         <= tb_next;
            half_sec_pulse <= (tb_next == HALF_LAST) || (tb_next == FULL_LAST);
            sec_pulse      <= (tb_next == FULL_LAST);
        end
    end

endmodule

// File: rtl/trip_odometer.sv
// Trip data source: reed conditioning, distance, moving flag, H:M:S timer and max speed.
// Define TRIP_AUTOPAUSE_EN to advance the ride timer only while the bike is moving.
module trip_odometer
    import trip_pkg::*;
#(
    parameter int CLK_FREQ     = 1000,
    parameter int CIRC_CM      = 218,
    parameter int DIST_UNIT_CM = 10000,
    parameter int DEBOUNCE_CYC = 20,
    parameter int STOP_TIMEOUT = 3
) (
    input logic            clock,
    input logic            reset,
    trip_odometer_if.slave bus
);

    localparam int LOCK_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int CM_W   = $clog2(DIST_UNIT_CM + CIRC_CM);
    localparam int IDLE_W = $clog2(STOP_TIMEOUT + 1);

    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(DEBOUNCE_CYC);
    localparam logic [CM_W-1:0]   CIRC       = CM_W'(CIRC_CM);
    localparam logic [CM_W-1:0]   UNIT       = CM_W'(DIST_UNIT_CM);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(STOP_TIMEOUT);
    localparam logic [IDLE_W:0]   IDLE_LIMIT = (IDLE_W + 1)'(STOP_TIMEOUT);

    logic               half_sec_pulse;
    logic               sec_pulse;
    logic               reed_s1;
    logic               reed_s2;
    logic               reed_d;
    logic               reed_rise;
    logic [LOCK_W-1:0]  lockout;
    logic               wheel_pulse;
    logic [CM_W-1:0]    cm_acc;
    logic [CM_W-1:0]    cm_sum;
    logic [DIST_W-1:0]  distance;
    logic [IDLE_W-1:0]  idle_s;
    logic [IDLE_W:0]    idle_inc;
    logic               moving;
    logic               tick;
    hms_t               hms;
    hms_t               hms_next;
    logic [SPEED_W-1:0] max_speed;

    trip_timebase #(
        .CLK_FREQ(CLK_FREQ)
    ) u_timebase (
        .clock         (clock),
        .reset         (reset),
        .half_sec_pulse(half_sec_pulse),
        .sec_pulse     (sec_pulse)
    );

    assign reed_rise = reed_s2 & ~reed_d;
    assign cm_sum    = cm_acc + CIRC;
    assign idle_inc  = {1'b0, idle_s} + 1'b1;

`ifdef TRIP_AUTOPAUSE_EN
    assign tick = sec_pulse & moving;
`else
    assign tick = sec_pulse;
`endif

    // NOTE: hms_next gets a full default first so no path through this block infers a latch.
    always_comb begin
        hms_next = hms;
        if (hms.seconds == MAX_MIN_SEC) begin
            hms_next.seconds = '0;
            if (hms.minutes == MAX_MIN_SEC) begin
                hms_next.minutes = '0;
                hms_next.hours   = (hms.hours == HMS_MAX_H) ? '0 : hms.hours + 1'b1;
            end else begin
                hms_next.minutes = hms.minutes + 1'b1;
            end
        end else begin
            hms_next.seconds = hms.seconds + 1'b1;
        end
    end

    // Reed conditioning is independent of trip_clear: only reset touches the synchronizer and lockout.
    always_ff @(posedge clock) begin
        if (reset) begin
            reed_s1     <= 1'b0;
            reed_s2     <= 1'b0;
            reed_d      <= 1'b0;
            lockout     <= '0;
            wheel_pulse <= 1'b0;
        end else begin
            reed_s1 <= bus.reed;
            reed_s2 <= reed_s1;
            reed_d  <= reed_s2;
            if (reed_rise && lockout == '0) begin
                wheel_pulse <= 1'b1;
                lockout     <= LOCK_LOAD;
            end else begin
                wheel_pulse <= 1'b0;
                if (lockout != '0) lockout <= lockout - 1'b1;
            end
        end
    end

    // Reset and trip_clear leave the trip data in the same state; clear beats any same-cycle event.
    always_ff @(posedge clock) begin
        if (reset || bus.trip_clear) begin
            cm_acc    <= '0;
            distance  <= '0;
            idle_s    <= IDLE_MAX;
            moving    <= 1'b0;
            hms       <= '0;
            max_speed <= '0;
        end else begin
            if (wheel_pulse) begin
                if (cm_sum >= UNIT) begin
                    cm_acc   <= cm_sum - UNIT;
                    distance <= (distance == DIST_MAX) ? '0 : distance + 1'b1;
                end else begin
                    cm_acc <= cm_sum;
                end
                idle_s <= '0;
                moving <= 1'b1;
            end else if (sec_pulse) begin
                idle_s <= (idle_s == IDLE_MAX) ? IDLE_MAX : idle_inc[IDLE_W-1:0];
                moving <= (idle_inc < IDLE_LIMIT);
            end
            if (tick) hms <= hms_next;
            if (bus.speed_valid && bus.speed > max_speed) max_speed <= bus.speed;
        end
    end

    assign bus.half_sec_pulse = half_sec_pulse;
    assign bus.sec_pulse      = sec_pulse;
    assign bus.wheel_pulse    = wheel_pulse;
    assign bus.moving         = moving;
    assign bus.distance       = distance;
    assign bus.HMS_time       = pack_hms(hms);
    assign bus.max_speed      = max_speed;

endmodule

// File: tb/tb_trip_odometer.sv
// Directed bench for trip_odometer: timebase, reed debounce, distance, moving, timer, max speed, reset.
module tb_trip_odometer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    trip_odometer_if bus ();
    trip_odometer_if wbus ();

    trip_odometer #(
        .CLK_FREQ(10), .CIRC_CM(218), .DIST_UNIT_CM(1000), .DEBOUNCE_CYC(4), .STOP_TIMEOUT(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // One wheel pulse per distance unit, so the 9999 -> 0 wrap is reachable in a short run.
    trip_odometer #(
        .CLK_FREQ(4), .CIRC_CM(218), .DIST_UNIT_CM(218), .DEBOUNCE_CYC(1), .STOP_TIMEOUT(3)
    ) dut_w (
        .clock(clock),
        .reset(reset),
        .bus  (wbus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int wp_cnt = 0;
    int wpw_cnt = 0;

    always @(negedge clock) begin
        if (bus.wheel_pulse === 1'b1) wp_cnt <= wp_cnt + 1;
        if (wbus.wheel_pulse === 1'b1) wpw_cnt <= wpw_cnt + 1;
    end

    typedef struct {
        logic [6:0]  speed;
        logic        valid;
        logic        clear;
        logic [6:0]  exp_max;
        logic [13:0] exp_dist;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [18:0] exp_hms(input int h, input int m, input int s);
        return {7'(h), 6'(m), 6'(s)};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_half"},   32'(bus.half_sec_pulse), 0);
        check({tag, "_sec"},    32'(bus.sec_pulse), 0);
        check({tag, "_wheel"},  32'(bus.wheel_pulse), 0);
        check({tag, "_moving"}, 32'(bus.moving), 0);
        check({tag, "_dist"},   32'(bus.distance), 0);
        check({tag, "_hms"},    32'(bus.HMS_time), 0);
        check({tag, "_max"},    32'(bus.max_speed), 0);
    endtask

    // Advance until a second pulse is visible; the next edge is then the end of a second.
    task automatic align_sec();
        int k = 0;
        while (bus.sec_pulse !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("align_sec_found", 32'(bus.sec_pulse), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        vecs[0] = '{7'd30,  1'b1, 1'b0, 7'd30,  14'd784};
        vecs[1] = '{7'd45,  1'b1, 1'b0, 7'd45,  14'd784};
        vecs[2] = '{7'd40,  1'b1, 1'b0, 7'd45,  14'd784};
        vecs[3] = '{7'd45,  1'b1, 1'b0, 7'd45,  14'd784};
        vecs[4] = '{7'd99,  1'b0, 1'b0, 7'd45,  14'd784};
        vecs[5] = '{7'd60,  1'b1, 1'b1, 7'd0,   14'd0};
        vecs[6] = '{7'd0,   1'b1, 1'b0, 7'd0,   14'd0};
        vecs[7] = '{7'd127, 1'b1, 1'b0, 7'd127, 14'd0};
        vecs[8] = '{7'd126, 1'b1, 1'b0, 7'd127, 14'd0};

        bus.reed = 1'b0;  bus.trip_clear = 1'b0;  bus.speed = '0;  bus.speed_valid = 1'b0;
        wbus.reed = 1'b0; wbus.trip_clear = 1'b0; wbus.speed = '0; wbus.speed_valid = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Timebase: cycle c holds tb_cnt == c mod 10
        for (int c = 0; c < 30; c++) begin
            check($sformatf("half_c%0d", c), 32'(bus.half_sec_pulse), 32'(c % 5 == 4));
            check($sformatf("sec_c%0d", c),  32'(bus.sec_pulse),      32'(c % 10 == 9));
            tick();
        end

        // Reed bounce, then five clean pulses
        base = wp_cnt;
        bus.reed = 1'b1;
        tick();
        check("wheel_edge1", 32'(bus.wheel_pulse), 0);
        tick();
        check("wheel_edge2", 32'(bus.wheel_pulse), 0);
        bus.reed = 1'b0;
        tick();
        check("wheel_edge3", 32'(bus.wheel_pulse), 1);
        bus.reed = 1'b1;
        repeat (6) tick();
        bus.reed = 1'b0;
        repeat (12) tick();
        check("bounce_dropped", 32'(wp_cnt - base), 1);
        for (int i = 0; i < 5; i++) begin
            bus.reed = 1'b1;
            tick();
            tick();
            bus.reed = 1'b0;
            tick();
            check($sformatf("clean_wheel_%0d", i), 32'(bus.wheel_pulse), 1);
            check($sformatf("clean_dist_pre_%0d", i), 32'(bus.distance), 32'(((i + 1) * 218) / 1000));
            tick();
            check($sformatf("clean_dist_post_%0d", i), 32'(bus.distance), 32'(((i + 2) * 218) / 1000));
            repeat (16) tick();
        end
        check("wheel_count", 32'(wp_cnt - base), 6);

        // One hour of riding, one wheel pulse per second
        align_sec();
        bus.trip_clear = 1'b1;
        tick();
        bus.trip_clear = 1'b0;
        check("clear_dist", 32'(bus.distance), 0);
        check("clear_hms", 32'(bus.HMS_time), 0);
        check("clear_moving", 32'(bus.moving), 0);
        for (int s = 0; s < 3600; s++) begin
            bus.reed = 1'b1;
            tick();
            tick();
            bus.reed = 1'b0;
            repeat (8) tick();
            if (s == 59) begin
                check("hms_1min", 32'(bus.HMS_time), 32'(exp_hms(0, 1, 0)));
                check("dist_1min", 32'(bus.distance), 13);
            end
        end
        check("hms_1h", 32'(bus.HMS_time), 32'(exp_hms(1, 0, 0)));
        check("dist_1h", 32'(bus.distance), 784);
        check("moving_riding", 32'(bus.moving), 1);

        // Stop: moving drops on the third second pulse after the last wheel pulse
        repeat (10) tick();
        check("moving_stop_2s", 32'(bus.moving), 1);
        repeat (10) tick();
        check("moving_stop_3s", 32'(bus.moving), 0);
        check("hms_at_stop", 32'(bus.HMS_time), 32'(exp_hms(1, 0, 2)));
        repeat (20) tick();
        check("moving_stopped", 32'(bus.moving), 0);
`ifdef TRIP_AUTOPAUSE_EN
        check("hms_paused", 32'(bus.HMS_time), 32'(exp_hms(1, 0, 2)));
`else
        check("hms_running", 32'(bus.HMS_time), 32'(exp_hms(1, 0, 4)));
`endif
        check("dist_stopped", 32'(bus.distance), 784);

        // Max speed table; one vector also clears the trip
        for (int i = 0; i < 9; i++) begin
            bus.speed       = vecs[i].speed;
            bus.speed_valid = vecs[i].valid;
            bus.trip_clear  = vecs[i].clear;
            tick();
            check($sformatf("vec%0d_max", i),  32'(bus.max_speed), 32'(vecs[i].exp_max));
            check($sformatf("vec%0d_dist", i), 32'(bus.distance),  32'(vecs[i].exp_dist));
        end
        bus.speed_valid = 1'b0;
        bus.trip_clear  = 1'b0;
        bus.speed       = '0;

        // trip_clear beats a same-cycle wheel pulse
        repeat (10) tick();
        bus.reed = 1'b1;
        tick();
        tick();
        bus.reed = 1'b0;
        tick();
        check("clr_vs_wheel_pulse", 32'(bus.wheel_pulse), 1);
        bus.trip_clear = 1'b1;
        tick();
        bus.trip_clear = 1'b0;
        check("clr_vs_wheel_moving", 32'(bus.moving), 0);
        check("clr_vs_wheel_dist", 32'(bus.distance), 0);

        // Distance wrap 9999 -> 0
        base = wpw_cnt;
        for (int n = 0; n < 9999; n++) begin
            wbus.reed = 1'b1;
            tick();
            wbus.reed = 1'b0;
            tick();
        end
        repeat (4) tick();
        check("wrap_pulse_count", 32'(wpw_cnt - base), 9999);
        check("wrap_dist_max", 32'(wbus.distance), 9999);
        wbus.reed = 1'b1;
        tick();
        wbus.reed = 1'b0;
        repeat (5) tick();
        check("wrap_dist_zero", 32'(wbus.distance), 0);

        // Reset mid-lockout with 00:01:07 on the timer
        align_sec();
        bus.trip_clear = 1'b1;
        tick();
        bus.trip_clear  = 1'b0;
        bus.speed       = 7'd50;
        bus.speed_valid = 1'b1;
        tick();
        bus.speed_valid = 1'b0;
        repeat (669) tick();
`ifdef TRIP_AUTOPAUSE_EN
        check("pre_reset_hms", 32'(bus.HMS_time), 32'(exp_hms(0, 0, 0)));
`else
        check("pre_reset_hms", 32'(bus.HMS_time), 32'(exp_hms(0, 1, 7)));
`endif
        check("pre_reset_max", 32'(bus.max_speed), 50);
        bus.reed = 1'b1;
        tick();
        tick();
        bus.reed = 1'b0;
        tick();
        check("pre_reset_wheel", 32'(bus.wheel_pulse), 1);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        bus.reed = 1'b1;
        tick();
        tick();
        bus.reed = 1'b0;
        tick();
        check("post_reset_wheel", 32'(bus.wheel_pulse), 1);
        tick();
        check("post_reset_moving", 32'(bus.moving), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
